ebu_arbiter: RTL

Two-manager AHB-Lite arbiter for the external bus unit. It sits directly downstream of the IFU and LSU cache/bus interfaces and merges their two manager-side AHB streams into the single AHB port that drives the system bus. Each manager has a one-entry input stage that captures its address phase when it is not granted, and stalls it until granted. The LSU has priority from idle. Ownership alternates between the two managers when both wait, and it changes only at burst boundaries.

---
 rtl/ebu_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ebu_arbiter.sv
// ebu_arbiter: two-manager AHB-Lite arbiter for the external bus unit.
//
// Merges the IFU and LSU manager-side AHB streams onto one system-bus port.
// Each manager has a one-entry input stage. The stage captures an address
// phase that arrives while the other manager owns the bus, and it stalls the
// manager until that phase is granted. From idle the LSU has priority.
// Ownership changes only at burst boundaries, so two managers that keep
// requesting alternate burst by burst.
//
// Ports
//   clk, reset                 bus clock; synchronous active-high reset
//   IH* / LH*                  IFU / LSU address phase (TRANS, WRITE, SIZE,
//                              BURST, ADDR) and data phase (WDATA, WSTRB)
//   IHREADY / LHREADY          per-manager HREADY returned to each interface
//   HREADY                     subordinate ready
//   HTRANS..HADDR              muxed address phase towards the system bus
//   HWDATA / HWSTRB            muxed write data, selected by the data-phase owner
module ebu_arbiter #(
  parameter int PA_BITS = 56,
  parameter int AHBW    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         IHTRANS,
  input  logic               IHWRITE,
  input  logic [2:0]         IHSIZE,
  input  logic [2:0]         IHBURST,
  input  logic [PA_BITS-1:0] IHADDR,
  input  logic [AHBW-1:0]    IHWDATA,
  input  logic [AHBW/8-1:0]  IHWSTRB,
  output logic               IHREADY,
  input  logic [1:0]         LHTRANS,
  input  logic               LHWRITE,
  input  logic [2:0]         LHSIZE,
  input  logic [2:0]         LHBURST,
  input  logic [PA_BITS-1:0] LHADDR,
  input  logic [AHBW-1:0]    LHWDATA,
  input  logic [AHBW/8-1:0]  LHWSTRB,
  output logic               LHREADY,
  input  logic               HREADY,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [PA_BITS-1:0] HADDR,
  output logic [AHBW-1:0]    HWDATA,
  output logic [AHBW/8-1:0]  HWSTRB
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IFU  = 2'd1;
  localparam logic [1:0] ST_LSU  = 2'd2;

  // Index of the final beat for a burst encoding; undefined-length and
  // wrapping encodings are treated as single transfers.
  function automatic logic [3:0] last_idx(input logic [2:0] burst);
    case (burst)
      3'b011:  last_idx = 4'd3;
      3'b101:  last_idx = 4'd7;
      3'b111:  last_idx = 4'd15;
      default: last_idx = 4'd0;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pend_i_q, pend_i_d, pend_l_q, pend_l_d;
  logic               dvalid_q, dvalid_d;
  logic               downer_q, downer_d;   // 1 = LSU owns the data phase

  logic [1:0]         i_trans_q, i_trans_d, l_trans_q, l_trans_d;
  logic               i_write_q, i_write_d, l_write_q, l_write_d;
  logic [2:0]         i_size_q, i_size_d, l_size_q, l_size_d;
  logic [2:0]         i_burst_q, i_burst_d, l_burst_q, l_burst_d;
  logic [PA_BITS-1:0] i_addr_q, i_addr_d, l_addr_q, l_addr_d;

  // Last address phase driven, replayed while nobody owns the bus.
  logic               hwrite_q, hwrite_d;
  logic [2:0]         hsize_q, hsize_d;
  logic [2:0]         hburst_q, hburst_d;
  logic [PA_BITS-1:0] haddr_q, haddr_d;

  logic               i_req_live, l_req_live, i_req, l_req;
  logic [1:0]         owner;
  logic               own_i, own_l;
  logic               beat_acc, last_beat;

  // A manager already held in its input stage is not offering a new phase:
  // it was stalled by a low xHREADY and is presenting its next transfer.
  always_comb begin
    i_req_live = (IHTRANS != 2'b00) && !pend_i_q;
    l_req_live = (LHTRANS != 2'b00) && !pend_l_q;
    i_req      = pend_i_q || i_req_live;
    l_req      = pend_l_q || l_req_live;
    case (state_q)
      ST_IFU:  owner = ST_IFU;
      ST_LSU:  owner = ST_LSU;
      default: owner = l_req ? ST_LSU : (i_req ? ST_IFU : ST_IDLE);
    endcase
    own_i = (owner == ST_IFU);
    own_l = (owner == ST_LSU);
  end

  always_comb begin
    HTRANS = 2'b00;
    HWRITE = hwrite_q;
    HSIZE  = hsize_q;
    HBURST = hburst_q;
    HADDR  = haddr_q;
    if (own_l) begin
      HTRANS = pend_l_q ? l_trans_q : LHTRANS;
      HWRITE = pend_l_q ? l_write_q : LHWRITE;
      HSIZE  = pend_l_q ? l_size_q  : LHSIZE;
      HBURST = pend_l_q ? l_burst_q : LHBURST;
      HADDR  = pend_l_q ? l_addr_q  : LHADDR;
    end else if (own_i) begin
      HTRANS = pend_i_q ? i_trans_q : IHTRANS;
      HWRITE = pend_i_q ? i_write_q : IHWRITE;
      HSIZE  = pend_i_q ? i_size_q  : IHSIZE;
      HBURST = pend_i_q ? i_burst_q : IHBURST;
      HADDR  = pend_i_q ? i_addr_q  : IHADDR;
    end
  end

  // A pending stage holds its manager even in the cycle it is granted, since
  // that manager already treated the captured phase as accepted.
  always_comb begin
    HWDATA = downer_q ? LHWDATA : IHWDATA;
    HWSTRB = downer_q ? LHWSTRB : IHWSTRB;
    if (pend_i_q)
      IHREADY = 1'b0;
    else if ((dvalid_q && !downer_q) || own_i)
      IHREADY = HREADY;
    else
      IHREADY = 1'b1;
    if (pend_l_q)
      LHREADY = 1'b0;
    else if ((dvalid_q && downer_q) || own_l)
      LHREADY = HREADY;
    else
      LHREADY = 1'b1;
  end

  // BUSY beats do not advance the burst.
  assign beat_acc  = HREADY && HTRANS[1];
  assign last_beat = beat_acc && (cnt_q == last_idx(HBURST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_i_d  = pend_i_q;
    pend_l_d  = pend_l_q;
    dvalid_d  = dvalid_q;
    downer_d  = downer_q;
    i_trans_d = i_trans_q;
    i_write_d = i_write_q;
    i_size_d  = i_size_q;
    i_burst_d = i_burst_q;
    i_addr_d  = i_addr_q;
    l_trans_d = l_trans_q;
    l_write_d = l_write_q;
    l_size_d  = l_size_q;
    l_burst_d = l_burst_q;
    l_addr_d  = l_addr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hburst_d  = hburst_q;
    haddr_d   = haddr_q;
    if (owner != ST_IDLE) begin
      hwrite_d = HWRITE;
      hsize_d  = HSIZE;
      hburst_d = HBURST;
      haddr_d  = HADDR;
    end
    if (HREADY) begin
      if (owner != ST_IDLE) begin
        if (last_beat) begin
          cnt_d = 4'd0;
          if (own_l)
            state_d = i_req ? ST_IFU : ST_IDLE;
          else
            state_d = l_req ? ST_LSU : ST_IDLE;
        end else begin
          state_d = owner;
          if (beat_acc)
            cnt_d = cnt_q + 4'd1;
        end
        downer_d = own_l;
      end
      dvalid_d = (HTRANS != 2'b00);
      if (i_req_live && !own_i) begin
        pend_i_d  = 1'b1;
        i_trans_d = IHTRANS;
        i_write_d = IHWRITE;
        i_size_d  = IHSIZE;
        i_burst_d = IHBURST;
        i_addr_d  = IHADDR;
      end else if (own_i) begin
        pend_i_d = 1'b0;
      end
      if (l_req_live && !own_l) begin
        pend_l_d  = 1'b1;
        l_trans_d = LHTRANS;
        l_write_d = LHWRITE;
        l_size_d  = LHSIZE;
        l_burst_d = LHBURST;
        l_addr_d  = LHADDR;
      end else if (own_l) begin
        pend_l_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      pend_i_q <= 1'b0;
      pend_l_q <= 1'b0;
      dvalid_q <= 1'b0;
      downer_q <= 1'b1;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      hburst_q <= 3'd0;
      haddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_i_q <= pend_i_d;
      pend_l_q <= pend_l_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      haddr_q  <= haddr_d;
    end
  end

  // Captured phases are only observed while their pending flag is set.
  always_ff @(posedge clk) begin
    i_trans_q <= i_trans_d;
    i_write_q <= i_write_d;
    i_size_q  <= i_size_d;
    i_burst_q <= i_burst_d;
    i_addr_q  <= i_addr_d;
    l_trans_q <= l_trans_d;
    l_write_q <= l_write_d;
    l_size_q  <= l_size_d;
    l_burst_q <= l_burst_d;
    l_addr_q  <= l_addr_d;
  end

endmodule
